approx_controller: RTL

Control FSM for the Taylor-series approximation datapath. It accepts a start request and an iteration count from the host and sequences the datapath's write-enable, register-transfer and ALU-mode signals one ALU operation at a time. It uses the datapath's `valid_o` termination flag to end the series and reports completion to the host. It sits between the host interface and the datapath, as the counterpart that drives every datapath control input.

---
 rtl/approx_pkg.sv | 103 ++++++++++
 rtl/op_timer.sv | 42 ++++
 rtl/approx_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/approx_pkg.sv
// Shared definitions for the Taylor-series controller: ALU modes, FSM states,
// and the decode from controller state to the registered datapath control word.
package approx_pkg;

  localparam int ALU_LAT_DEF = 2;
  localparam int MAX_IT_DEF  = 7;

  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_SUB1 = 3'd1;
  localparam logic [2:0] MODE_MUL  = 3'd2;
  localparam logic [2:0] MODE_ACC  = 3'd3;
  localparam logic [2:0] MODE_INC  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_LOAD  = 4'd2,
    ST_X1    = 4'd3,
    ST_X1N   = 4'd4,
    ST_MUL   = 4'd5,
    ST_ACC   = 4'd6,
    ST_CHK   = 4'd7,
    ST_INC   = 4'd8,
    ST_DONE  = 4'd9
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       dp_start;
    logic       check;
    logic [2:0] mode;
    logic       wren_x1;
    logic       wren_x1_n;
    logic       wren_x1_n_mult;
    logic       wren_y;
    logic       wren_n;
    logic       wren_sigma_n;
    logic       x_to_a;
    logic       y_to_a;
    logic       x1_to_a;
    logic       n_to_a;
    logic       x1_n_to_b;
    logic       sigma_to_alu;
  } ctrl_t;

  function automatic logic is_op(state_t s);
    return (s == ST_X1) || (s == ST_X1N) || (s == ST_MUL) ||
           (s == ST_ACC) || (s == ST_CHK) || (s == ST_INC);
  endfunction

  // Selects and mode hold for the whole op; write flags only when wb is set.
  function automatic ctrl_t decode_ctrl(state_t s, logic wb, logic err);
    ctrl_t c;
    c      = '0;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_START: c.dp_start = 1'b1;
      ST_X1: begin
        c.x_to_a  = 1'b1;
        c.mode    = MODE_SUB1;
        c.wren_x1 = wb;
      end
      ST_X1N: begin
        c.x1_to_a   = 1'b1;
        c.mode      = MODE_PASS;
        c.wren_x1_n = wb;
      end
      ST_MUL: begin
        c.x1_to_a        = 1'b1;
        c.x1_n_to_b      = 1'b1;
        c.mode           = MODE_MUL;
        c.wren_x1_n_mult = wb;
      end
      ST_ACC: begin
        c.y_to_a       = 1'b1;
        c.x1_n_to_b    = 1'b1;
        c.sigma_to_alu = 1'b1;
        c.mode         = MODE_ACC;
        c.wren_y       = wb;
      end
      ST_CHK: begin
        c.n_to_a = 1'b1;
        c.mode   = MODE_PASS;
        c.check  = wb;
      end
      ST_INC: begin
        c.n_to_a       = 1'b1;
        c.mode         = MODE_INC;
        c.wren_n       = wb;
        c.wren_sigma_n = wb;
      end
      ST_DONE: begin
        c.done = 1'b1;
        c.err  = err;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/op_timer.sv
// Per-op latency counter: loaded with ALU_LAT on op entry, in_wb marks the
// write-back cycle, wb_next predicts it one cycle ahead for registered outputs.
module op_timer #(
  parameter int ALU_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic in_wb,
  output logic wb_next
);

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  logic [3:0] cnt_r;

  // Count down to zero and hold there until the next op is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= LAT;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign in_wb = (cnt_r == 4'd0);

  // Write-back status of the cycle after the coming edge.
  always_comb begin
    wb_next = 1'b0;
    if (load) begin
      wb_next = (LAT == 4'd0);
    end else if (cnt_r == 4'd0) begin
      wb_next = 1'b1;
    end else begin
      wb_next = (cnt_r == 4'd1);
    end
  end

endmodule

// File: rtl/approx_controller.sv
// Control FSM sequencing the Taylor-series datapath one ALU op at a time and
// reporting completion (or guard abort) to the host.
module approx_controller
  import approx_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int MAX_IT  = MAX_IT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [2:0] numIt_i,
  input  logic       valid_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       dp_start_o,
  output logic       check_o,
  output logic [2:0] mode_o,
  output logic       wren_x1_o,
  output logic       wren_x1_n_o,
  output logic       wren_x1_n_mult_o,
  output logic       wren_y_o,
  output logic       wren_n_o,
  output logic       wren_sigma_n_o,
  output logic       x_to_a_o,
  output logic       y_to_a_o,
  output logic       x1_to_a_o,
  output logic       n_to_a_o,
  output logic       x1_n_to_b_o,
  output logic       sigma_to_alu_o
);

  localparam logic [2:0] LAST_IT = 3'(MAX_IT - 1);

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] nit_r;
  logic [2:0] it_cnt_r;
  logic       err_r;
  logic       err_next_s;
  logic       load_2nd_r;
  logic       tmr_load_s;
  logic       in_wb_s;
  logic       wb_next_s;
  ctrl_t      ctrl_r;

  op_timer #(.ALU_LAT(ALU_LAT)) u_op_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load_s),
    .in_wb   (in_wb_s),
    .wb_next (wb_next_s)
  );

  // Next-state and abort decision; op states advance only on write-back.
  always_comb begin
    next_state_s = state_r;
    err_next_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        err_next_s = 1'b0;
        if (start_i) next_state_s = ST_START;
        else         next_state_s = ST_IDLE;
      end
      ST_START: next_state_s = ST_LOAD;
      ST_LOAD: begin
        if (!load_2nd_r)         next_state_s = ST_LOAD;
        else if (nit_r == 3'd0)  next_state_s = ST_DONE;
        else                     next_state_s = ST_X1;
      end
      ST_X1:  if (in_wb_s) next_state_s = ST_X1N; else next_state_s = ST_X1;
      ST_X1N: if (in_wb_s) next_state_s = ST_ACC; else next_state_s = ST_X1N;
      ST_MUL: if (in_wb_s) next_state_s = ST_ACC; else next_state_s = ST_MUL;
      ST_ACC: if (in_wb_s) next_state_s = ST_CHK; else next_state_s = ST_ACC;
      ST_CHK: begin
        if (!in_wb_s) begin
          next_state_s = ST_CHK;
        end else if (valid_i) begin
          next_state_s = ST_DONE;
        end else if (it_cnt_r == LAST_IT) begin
          next_state_s = ST_DONE;
          err_next_s   = 1'b1;
        end else begin
          next_state_s = ST_INC;
        end
      end
      ST_INC:  if (in_wb_s) next_state_s = ST_MUL; else next_state_s = ST_INC;
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  assign tmr_load_s = is_op(next_state_s) && (next_state_s != state_r);

  // State, iteration bookkeeping and control word registered for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      nit_r      <= 3'd0;
      it_cnt_r   <= 3'd0;
      err_r      <= 1'b0;
      load_2nd_r <= 1'b0;
      ctrl_r     <= '0;
    end else begin
      state_r    <= next_state_s;
      err_r      <= err_next_s;
      load_2nd_r <= (state_r == ST_LOAD);
      ctrl_r     <= decode_ctrl(next_state_s, wb_next_s, err_next_s);
      if (state_r == ST_IDLE && start_i) begin
        nit_r    <= numIt_i;
        it_cnt_r <= 3'd0;
      end else if (state_r == ST_INC && in_wb_s) begin
        it_cnt_r <= it_cnt_r + 3'd1;
      end
    end
  end

  assign busy_o           = ctrl_r.busy;
  assign done_o           = ctrl_r.done;
  assign err_o            = ctrl_r.err;
  assign dp_start_o       = ctrl_r.dp_start;
  assign check_o          = ctrl_r.check;
  assign mode_o           = ctrl_r.mode;
  assign wren_x1_o        = ctrl_r.wren_x1;
  assign wren_x1_n_o      = ctrl_r.wren_x1_n;
  assign wren_x1_n_mult_o = ctrl_r.wren_x1_n_mult;
  assign wren_y_o         = ctrl_r.wren_y;
  assign wren_n_o         = ctrl_r.wren_n;
  assign wren_sigma_n_o   = ctrl_r.wren_sigma_n;
  assign x_to_a_o         = ctrl_r.x_to_a;
  assign y_to_a_o         = ctrl_r.y_to_a;
  assign x1_to_a_o        = ctrl_r.x1_to_a;
  assign n_to_a_o         = ctrl_r.n_to_a;
  assign x1_n_to_b_o      = ctrl_r.x1_n_to_b;
  assign sigma_to_alu_o   = ctrl_r.sigma_to_alu;

endmodule
